// File: rtl/pld_fsw_debounce.sv
// pld_fsw_debounce: footswitch synchroniser, debouncer and bypass toggle.
// Define FSW_LONG_PRESS_EN to build the long-press counter and strobe.
module pld_fsw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter logic        BYPASS_RESET      = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic fsw_n,
  output logic fsw_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic bypass,
  output logic long_press
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 ||
      LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("pld_fsw_debounce: bad cycle parameters");
  end

`ifdef FSW_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LMAX = LW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {UP, DOWN, LONG} state_t;

  logic [LW-1:0] lcnt;
`else
  typedef enum logic {UP, DOWN} state_t;
`endif

  state_t        state;
  logic [1:0]    sync;
  logic [DW-1:0] dcnt;
  logic          fsw_s;
  logic          differ;
  logic          accept;

  // sync[1] is the second flop; the pin is active-low
  assign fsw_s  = ~sync[1];
  assign differ = fsw_s != fsw_level;
  assign accept = differ && (dcnt == DMAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync          <= 2'b11;
      dcnt          <= '0;
      fsw_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      bypass        <= BYPASS_RESET;
      state         <= UP;
`ifdef FSW_LONG_PRESS_EN
      lcnt          <= '0;
      long_press    <= 1'b0;
`endif
    end else begin
      sync          <= {sync[0], fsw_n};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      dcnt          <= (differ && !accept) ? dcnt + 1'b1 : '0;
      if (accept) fsw_level <= ~fsw_level;
`ifdef FSW_LONG_PRESS_EN
      long_press    <= 1'b0;
`endif
      unique case (state)
        UP: begin
`ifdef FSW_LONG_PRESS_EN
          lcnt <= '0;
`endif
          if (accept) begin
            press_pulse <= 1'b1;
            bypass      <= ~bypass;
            state       <= DOWN;
          end
        end
        DOWN: begin
          if (accept) begin
            release_pulse <= 1'b1;
            state         <= UP;
          end
`ifdef FSW_LONG_PRESS_EN
          else if (lcnt == LMAX) begin
            long_press <= 1'b1;
            state      <= LONG;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
`endif
        end
`ifdef FSW_LONG_PRESS_EN
        LONG: begin
          if (accept) begin
            release_pulse <= 1'b1;
            state         <= UP;
          end
        end
`endif
        default: state <= UP;
      endcase
    end
  end

`ifndef FSW_LONG_PRESS_EN
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_pld_fsw_debounce.sv
// tb_pld_fsw_debounce: randomized and directed checks of pld_fsw_debounce
// against a window-based reference model.
module tb_pld_fsw_debounce;

  localparam int D = 8;
  localparam int L = 32;
`ifdef FSW_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic fsw_n = 1'b1;
  logic fsw_level, press_pulse, release_pulse, bypass, long_press;
  logic [4:0] obs;

  pld_fsw_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L),
    .BYPASS_RESET(1'b1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .fsw_n(fsw_n),
    .fsw_level(fsw_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .bypass(bypass),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  assign obs = {fsw_level, press_pulse, release_pulse, bypass, long_press};

  int n_cmp = 0;
  int n_bad = 0;

  // model: t counts cycles since reset release; pq[k] = pin at cycle k-2
  int t;
  bit pq[$];
  bit fq[$];
  bit m_lvl, m_byp;
  int lf, pt;
  logic [4:0] exp_v;

  task automatic model_reset(input bit p);
    pq = {1'b1, 1'b1, p};
    fq = {1'b0};
    t = 0;
    m_lvl = 1'b0;
    m_byp = 1'b1;
    lf = 0;
    pt = -100000;
    exp_v = 5'b00010;
  endtask

  // level flips once D consecutive synchronised samples differ from it
  task automatic step(input bit p);
    bit fl, e_pr, e_rl, e_lp;
    @(posedge clk);
    #1;
    t++;
    fl = (t - D >= lf);
    if (fl)
      for (int k = t - D; k < t; k++)
        if (fq[k] == m_lvl) fl = 1'b0;
    e_pr = fl && !m_lvl;
    e_rl = fl && m_lvl;
    e_lp = LP_EN && m_lvl && !fl && (t - pt == L);
    if (fl) begin
      m_lvl = ~m_lvl;
      lf = t;
      if (m_lvl) begin
        m_byp = ~m_byp;
        pt = t;
      end
    end
    fq.push_back(~pq[t]);
    exp_v = {m_lvl, e_pr, e_rl, m_byp, e_lp};
    fsw_n = p;
    pq.push_back(p);
  endtask

  task automatic do_reset(input bit p);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    fsw_n = p;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 5'b00010) begin
      n_bad++;
      $display("FAIL in_reset got %b want %b", obs, 5'b00010);
    end
    resetn = 1'b1;
    model_reset(p);
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    n_cmp++;
    if (obs !== 5'b00010) begin
      n_bad++;
      $display("FAIL reset_release got %b want %b", obs, 5'b00010);
    end
    repeat (100) begin
      step(1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL idle t=%0d got %b want %b", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_press;
    int c0, seen;
    logic byp_at;
    c0 = t + 1;
    seen = -1;
    byp_at = 1'bx;
    repeat (30) begin
      step(1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL press t=%0d got %b want %b", t, obs, exp_v);
      end
      if (press_pulse === 1'b1 && seen < 0) begin
        seen = t;
        byp_at = bypass;
      end
    end
    n_cmp++;
    if (seen !== c0 + 10 || byp_at !== 1'b0) begin
      n_bad++;
      $display("FAIL press_time got %0d/%b want %0d/0",
               seen, byp_at, c0 + 10);
    end
    repeat (30) begin
      step(1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL press_rel t=%0d got %b want %b", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce;
    bit pat[$];
    int strobes, lv;
    bit byp0;
    byp0 = m_byp;
    strobes = 0;
    lv = 0;
    repeat (5) pat.push_back(1'b0);
    pat.push_back(1'b1);
    repeat (5) pat.push_back(1'b0);
    repeat (30) pat.push_back(1'b1);
    foreach (pat[i]) begin
      step(pat[i]);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL bounce t=%0d got %b want %b", t, obs, exp_v);
      end
      if (press_pulse || release_pulse || long_press) strobes++;
      if (fsw_level) lv++;
    end
    n_cmp++;
    if (strobes != 0 || lv != 0 || bypass !== byp0) begin
      n_bad++;
      $display("FAIL bounce_sum got %0d/%0d/%b want 0/0/%b",
               strobes, lv, bypass, byp0);
    end
  endtask

  task automatic test_press_release;
    int np, nr, tp, tr, nb;
    logic prev_b;
    np = 0; nr = 0; tp = 0; tr = 0; nb = 0;
    prev_b = bypass;
    for (int i = 0; i < 55; i++) begin
      step(i < 20 ? 1'b0 : 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL pr t=%0d got %b want %b", t, obs, exp_v);
      end
      if (press_pulse) begin np++; tp = t; end
      if (release_pulse) begin nr++; tr = t; end
      if (bypass !== prev_b) nb++;
      prev_b = bypass;
    end
    n_cmp++;
    if (np != 1 || nr != 1 || tr - tp != 20 || nb != 1) begin
      n_bad++;
      $display("FAIL pr_sum got %0d/%0d/%0d/%0d want 1/1/20/1",
               np, nr, tr - tp, nb);
    end
  endtask

  task automatic test_long;
    int nl, tp, tl;
    nl = 0; tp = 0; tl = 0;
    for (int i = 0; i < 90; i++) begin
      step(i < 60 ? 1'b0 : 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL long t=%0d got %b want %b", t, obs, exp_v);
      end
      if (press_pulse) tp = t;
      if (long_press) begin nl++; tl = t; end
    end
    n_cmp++;
    if (LP_EN ? (nl != 1 || tl - tp != L) : (nl != 0)) begin
      n_bad++;
      $display("FAIL long_sum got %0d at +%0d want %0d at +%0d",
               nl, tl - tp, LP_EN ? 1 : 0, L);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    logic byp_at;
    seen = -1;
    byp_at = 1'bx;
    repeat (20) begin
      step(1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL mid_pre t=%0d got %b want %b", t, obs, exp_v);
      end
    end
    do_reset(1'b0);
    repeat (15) begin
      step(1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL mid_post t=%0d got %b want %b", t, obs, exp_v);
      end
      if (press_pulse === 1'b1 && seen < 0) begin
        seen = t;
        byp_at = bypass;
      end
    end
    n_cmp++;
    if (seen !== 10 || byp_at !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_press got %0d/%b want 10/0", seen, byp_at);
    end
    repeat (20) step(1'b1);
  endtask

  task automatic test_random;
    bit p;
    int len;
    p = 1'b1;
    for (int n = 0; n < 600; n += len) begin
      p = ~p;
      len = $urandom_range(1, 14);
      repeat (len) begin
        step(($urandom_range(0, 19) == 0) ? ~p : p);
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL rand t=%0d got %b want %b", t, obs, exp_v);
        end
      end
    end
    repeat (40) begin
      step(1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL rand_tail t=%0d got %b want %b", t, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset;
    test_press;
    test_bounce;
    test_press_release;
    test_long;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
